// File: rtl/cnn_seq_pkg.sv
// Shared encodings and defaults for the CNN operand sequencer and its operand bank.
package cnn_seq_pkg;

   typedef enum logic [1:0] {
      OP_WINO   = 2'd0,
      OP_PRUNED = 2'd1,
      OP_CONV2D = 2'd2,
      OP_RELU   = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_EXEC = 3'd2,
      ST_WAIT = 3'd3,
      ST_DONE = 3'd4
   } seq_state_e;

   localparam int DEF_DATA_W     = 32;
   localparam int DEF_NUM_WORDS  = 14;
   localparam int DEF_RELU_WORDS = 2;
   localparam int SLOT_IDX_W     = $clog2(DEF_NUM_WORDS + 1);
   localparam int WAIT_W         = 4;

   // Operand words required by an op.
   function automatic int req_words(input logic [1:0] op, input int num_w, input int relu_w);
      return (op == OP_RELU) ? relu_w : num_w;
   endfunction

endpackage

// File: rtl/conv_opnd_bank.sv
// Operand register bank: NUM_WORDS x DATA_W slots, indexed write, synchronous clear.
module conv_opnd_bank
   import cnn_seq_pkg::*;
#(
   parameter int NUM_WORDS = DEF_NUM_WORDS,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int IDX_W     = SLOT_IDX_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        we,
   input  logic                        clr,
   input  logic [IDX_W-1:0]            widx,
   input  logic [DATA_W-1:0]           wdata,
   output logic [NUM_WORDS*DATA_W-1:0] opnd_bus
);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_WORDS; gi++) begin : g_slot
         logic [DATA_W-1:0] slot_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               slot_q <= '0;
            end else if (clr) begin
               slot_q <= '0;
            end else if (we && (widx == IDX_W'(gi))) begin
               slot_q <= wdata;
            end
         end

         assign opnd_bus[gi*DATA_W +: DATA_W] = slot_q;
      end
   endgenerate

endmodule

// File: rtl/conv_op_sequencer.sv
// Operand-collecting sequencer for the conv/relu datapaths: load, launch, wait, hold result.
// Optional cycle counter enabled by defining CONV_SEQ_PERF_EN.
module conv_op_sequencer
   import cnn_seq_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int NUM_WORDS  = DEF_NUM_WORDS,
   parameter int RELU_WORDS = DEF_RELU_WORDS,
   parameter int DP_LAT     = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [1:0]                  op_sel,
   input  logic                        load_valid,
   input  logic [DATA_W-1:0]           load_data,
   output logic                        load_ready,
   input  logic                        abort,
   output logic [NUM_WORDS*DATA_W-1:0] opnd_bus,
   output logic [1:0]                  dp_op,
   output logic                        dp_start,
   input  logic [DATA_W-1:0]           dp_result,
   output logic                        res_valid,
   output logic [DATA_W-1:0]           res_data,
   input  logic                        res_ready,
   output logic                        busy
`ifdef CONV_SEQ_PERF_EN
   ,
   input  logic                        perf_clr,
   output logic [15:0]                 perf_cycles
`endif
);

   localparam int CNT_W = $clog2(NUM_WORDS + 1);
   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(DP_LAT - 1);

   seq_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WAIT_W-1:0] wcnt_q, wcnt_d;
   logic [1:0]        dp_op_q, dp_op_d;
   logic [DATA_W-1:0] res_data_q, res_data_d;

   logic              ready_int;
   logic              accept;
   logic              first_accept;
   logic              bank_we;
   logic              bank_clr;
   logic [CNT_W-1:0]  cnt_inc;
   logic [CNT_W-1:0]  req_first;
   logic [CNT_W-1:0]  req_cur;

   assign ready_int    = (state_q == ST_IDLE) || (state_q == ST_LOAD);
   assign accept       = load_valid & ready_int & ~abort;
   assign first_accept = accept & (state_q == ST_IDLE);
   assign cnt_inc      = cnt_q + 1'b1;
   assign req_first    = CNT_W'(req_words(op_sel, NUM_WORDS, RELU_WORDS));
   assign req_cur      = CNT_W'(req_words(dp_op_q, NUM_WORDS, RELU_WORDS));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         wcnt_q     <= '0;
         dp_op_q    <= '0;
         res_data_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wcnt_q     <= wcnt_d;
         dp_op_q    <= dp_op_d;
         res_data_q <= res_data_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      wcnt_d     = wcnt_q;
      dp_op_d    = dp_op_q;
      res_data_d = res_data_q;
      bank_we    = 1'b0;
      bank_clr   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               dp_op_d = op_sel;
               bank_we = 1'b1;
               cnt_d   = cnt_inc;
               state_d = (req_first == CNT_W'(1)) ? ST_EXEC : ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (accept) begin
               bank_we = 1'b1;
               cnt_d   = cnt_inc;
               if (cnt_inc == req_cur) begin
                  state_d = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            wcnt_d  = WAIT_INIT;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (wcnt_q == '0) begin
               res_data_d = dp_result;
               state_d    = ST_DONE;
            end else begin
               wcnt_d = wcnt_q - 1'b1;
            end
         end
         ST_DONE: begin
            if (res_ready) begin
               bank_clr = 1'b1;
               cnt_d    = '0;
               state_d  = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Abort wins over everything, but a result already held is kept.
      if (abort) begin
         state_d    = ST_IDLE;
         cnt_d      = '0;
         bank_clr   = 1'b1;
         bank_we    = 1'b0;
         res_data_d = res_data_q;
      end
   end

   conv_opnd_bank #(
      .NUM_WORDS (NUM_WORDS),
      .DATA_W    (DATA_W),
      .IDX_W     (CNT_W)
   ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .we       (bank_we),
      .clr      (bank_clr),
      .widx     (cnt_q),
      .wdata    (load_data),
      .opnd_bus (opnd_bus)
   );

   assign load_ready = ready_int & ~rst;
   assign dp_start   = (state_q == ST_EXEC) & ~abort;
   assign res_valid  = (state_q == ST_DONE);
   assign busy       = (state_q != ST_IDLE);
   assign dp_op      = dp_op_q;
   assign res_data   = res_data_q;

`ifdef CONV_SEQ_PERF_EN
   logic [15:0] perf_q;
   logic        perf_run_q;

   // Counts from the first accept through the DONE-entry cycle, then freezes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_q     <= '0;
         perf_run_q <= 1'b0;
      end else if (perf_clr) begin
         perf_q     <= '0;
         perf_run_q <= 1'b0;
      end else if (first_accept) begin
         perf_q     <= 16'd1;
         perf_run_q <= 1'b1;
      end else if (perf_run_q) begin
         if (perf_q != 16'hFFFF) begin
            perf_q <= perf_q + 16'd1;
         end
         if ((state_q == ST_DONE) || abort) begin
            perf_run_q <= 1'b0;
         end
      end
   end

   assign perf_cycles = perf_q;
`else
   logic unused_first;
   assign unused_first = first_accept;
`endif

endmodule

// File: tb/tb_conv_op_sequencer.sv
// Scoreboard bench for conv_op_sequencer: directed loads, stalls, abort, reset and latency.
module tb_conv_op_sequencer;

   localparam int DW  = 32;
   localparam int NW  = 14;
   localparam int RW  = 2;
   localparam int LAT = 2;

   typedef struct {
      logic [DW-1:0]    res;
      logic [1:0]       op;
      logic [NW*DW-1:0] bus;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic [1:0]        op_sel;
   logic              load_valid;
   logic [DW-1:0]     load_data;
   logic              load_ready;
   logic              abort;
   logic [NW*DW-1:0]  opnd_bus;
   logic [1:0]        dp_op;
   logic              dp_start;
   logic [DW-1:0]     dp_result;
   logic              res_valid;
   logic [DW-1:0]     res_data;
   logic              res_ready;
   logic              busy;
`ifdef CONV_SEQ_PERF_EN
   logic              perf_clr;
   logic [15:0]       perf_cycles;
`endif

   exp_t          sb[$];
   int            n_checks = 0;
   int            n_fail   = 0;
   logic [DW-1:0] dp_val;
   logic [1:0]    dp_pipe;

   always #5 clk = ~clk;

   conv_op_sequencer #(
      .DATA_W     (DW),
      .NUM_WORDS  (NW),
      .RELU_WORDS (RW),
      .DP_LAT     (LAT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .op_sel     (op_sel),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .abort      (abort),
      .opnd_bus   (opnd_bus),
      .dp_op      (dp_op),
      .dp_start   (dp_start),
      .dp_result  (dp_result),
      .res_valid  (res_valid),
      .res_data   (res_data),
      .res_ready  (res_ready),
      .busy       (busy)
`ifdef CONV_SEQ_PERF_EN
      ,
      .perf_clr   (perf_clr),
      .perf_cycles(perf_cycles)
`endif
   );

   // Datapath model: result is only meaningful exactly LAT cycles after dp_start.
   always @(posedge clk or posedge rst) begin
      if (rst) dp_pipe <= '0;
      else     dp_pipe <= {dp_pipe[0], dp_start};
   end
   assign dp_result = dp_pipe[1] ? dp_val : 32'hDEAD_BEEF;

   task automatic chk(input string nm, input logic [NW*DW-1:0] act, input logic [NW*DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every result handshake.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && res_valid && res_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: got %0h expected none", res_data);
         end else begin
            e = sb.pop_front();
            chk("mon_res_data", res_data, e.res);
            chk("mon_dp_op", dp_op, e.op);
            chk("mon_opnd_bus", opnd_bus, e.bus);
            $display("result %0h op %0d taken", res_data, dp_op);
         end
      end
   end

   task automatic send_word(input logic [DW-1:0] w);
      load_valid = 1'b1;
      load_data  = w;
      @(posedge clk);
      #1;
   endtask

   task automatic run_load(input logic [1:0] op, input int n, input logic [DW-1:0] base,
                           input logic [DW-1:0] step, output logic [NW*DW-1:0] bus);
      logic [DW-1:0] w;
      bus    = '0;
      op_sel = op;
      for (int k = 0; k < n; k++) begin
         w = base + DW'(k) * step;
         bus[k*DW +: DW] = w;
         send_word(w);
         if (k == 0) op_sel = ~op;
      end
      load_valid = 1'b0;
   endtask

   task automatic finish_op(input exp_t e, input int hold, input string tag);
      int dstart = 0;
      int rcyc   = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (n == 1) begin
            chk({tag, "_dp_op"}, dp_op, e.op);
            chk({tag, "_bus_exec"}, opnd_bus, e.bus);
         end
         if (dp_start && dstart == 0) dstart = n;
         if (res_valid) begin
            rcyc = n;
            break;
         end
      end
      chk({tag, "_dp_start_lat"}, dstart, 1);
      chk({tag, "_res_valid_lat"}, rcyc, 4);
      if (rcyc != 0) begin
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, res_valid, 1'b1);
            chk({tag, "_hold_data"}, res_data, e.res);
            chk({tag, "_hold_ready"}, load_ready, 1'b0);
         end
      end
      @(posedge clk);
      #1;
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_idle_busy"}, busy, 1'b0);
      chk({tag, "_idle_bus"}, opnd_bus, '0);
      chk({tag, "_idle_valid"}, res_valid, 1'b0);
      chk({tag, "_idle_ready"}, load_ready, 1'b1);
   endtask

   initial begin
      exp_t             e;
      logic [NW*DW-1:0] bus;
      logic [DW-1:0]    w;

      rst        = 1'b1;
      op_sel     = 2'd0;
      load_valid = 1'b0;
      load_data  = '0;
      abort      = 1'b0;
      res_ready  = 1'b0;
      dp_val     = '0;
`ifdef CONV_SEQ_PERF_EN
      perf_clr   = 1'b0;
`endif
      #12;
      chk("rst_bus", opnd_bus, '0);
      chk("rst_dp_op", dp_op, 2'd0);
      chk("rst_dp_start", dp_start, 1'b0);
      chk("rst_res_valid", res_valid, 1'b0);
      chk("rst_res_data", res_data, '0);
      chk("rst_busy", busy, 1'b0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_load_ready", load_ready, 1'b1);

      // conv2d, words 1..14, op_sel changed after first word, result held 10 cycles
      dp_val = 32'hA5A5_0001;
      run_load(2'd2, NW, 32'd1, 32'd1, bus);
      e.res = dp_val; e.op = 2'd2; e.bus = bus;
      sb.push_back(e);
      $display("issue conv2d 14 words");
      finish_op(e, 10, "conv2d");

      // relu, two words, upper slots must stay zero
      dp_val = 32'h0000_0F80;
      run_load(2'd3, RW, 32'h0000_0F80, 32'd0, bus);
      e.res = dp_val; e.op = 2'd3; e.bus = bus;
      sb.push_back(e);
      $display("issue relu 2 words");
      finish_op(e, 0, "relu");

      // winograd with stalls: two idle cycles after every third word
      dp_val = 32'h1357_9BDF;
      bus    = '0;
      op_sel = 2'd0;
      for (int k = 0; k < NW; k++) begin
         w = 32'h100 + DW'(k);
         bus[k*DW +: DW] = w;
         send_word(w);
         if (k % 3 == 0 && k != NW - 1) begin
            load_valid = 1'b0;
            repeat (2) begin
               @(negedge clk);
               chk("stall_no_start", dp_start, 1'b0);
               chk("stall_ready", load_ready, 1'b1);
               @(posedge clk);
               #1;
            end
         end
      end
      load_valid = 1'b0;
      e.res = dp_val; e.op = 2'd0; e.bus = bus;
      sb.push_back(e);
      $display("issue winograd stalled 14 words");
      finish_op(e, 0, "stall");

      // abort together with the 7th word
      op_sel = 2'd1;
      for (int k = 0; k < 6; k++) send_word(32'h200 + DW'(k));
      load_data  = 32'h0000_0206;
      abort      = 1'b1;
      @(posedge clk);
      #1;
      abort      = 1'b0;
      load_valid = 1'b0;
      @(negedge clk);
      chk("abort_busy", busy, 1'b0);
      chk("abort_bus", opnd_bus, '0);
      chk("abort_ready", load_ready, 1'b1);
      chk("abort_valid", res_valid, 1'b0);
      $display("abort on 7th word");

      // full gap-free winograd after abort
      dp_val = 32'hCAFE_0042;
      run_load(2'd0, NW, 32'h300, 32'd3, bus);
      e.res = dp_val; e.op = 2'd0; e.bus = bus;
      sb.push_back(e);
      $display("issue winograd after abort");
      finish_op(e, 0, "post_abort");
`ifdef CONV_SEQ_PERF_EN
      chk("perf_cycles", perf_cycles, 16'd18);
      @(posedge clk);
      #1;
      perf_clr = 1'b1;
      @(posedge clk);
      #1;
      perf_clr = 1'b0;
      chk("perf_clr", perf_cycles, 16'd0);
`endif

      // reset asserted asynchronously in WAIT
      dp_val = 32'h0BAD_0BAD;
      run_load(2'd2, NW, 32'h400, 32'd1, bus);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_bus", opnd_bus, '0);
      chk("arst_dp_op", dp_op, 2'd0);
      chk("arst_dp_start", dp_start, 1'b0);
      chk("arst_res_valid", res_valid, 1'b0);
      chk("arst_res_data", res_data, '0);
      chk("arst_busy", busy, 1'b0);
      $display("async reset in WAIT");
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         chk("arst_no_valid", res_valid, 1'b0);
      end

      chk("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/conv_op_sequencer.md
Name: conv_op_sequencer

Overview:
- Sequencer that collects the CNN operand words (one 32-bit word per cycle) into an operand register bank.
- Launches the selected convolution/activation datapath, waits its fixed latency, then captures and holds the 32-bit result until the consumer takes it.
- Sits between the register-file/load path and the winograd, pruned-winograd, conv2d and relu datapaths.
- Gives operand loading an explicit handshake and a defined word order, and clears the bank after every operation.

Parameters:
- DATA_W, 32, operand/result word width
- NUM_WORDS, 14, operand words for winograd/pruned/conv2d ops
- RELU_WORDS, 2, operand words for relu op
- DP_LAT, 2, datapath latency in cycles from dp_start to valid dp_result (legal range 1..15)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- op_sel  in  2  0=winograd, 1=pruned winograd, 2=conv2d, 3=relu; sampled on first accepted word
- load_valid  in  1  load_data valid
- load_data  in  DATA_W  operand word
- load_ready  out  1  sequencer accepts a word this cycle
- abort  in  1  synchronous cancel
- opnd_bus  out  NUM_WORDS*DATA_W  operand bank; slot k at bits [k*DATA_W +: DATA_W]
- dp_op  out  2  latched op to datapath
- dp_start  out  1  one-cycle launch pulse
- dp_result  in  DATA_W  datapath result
- res_valid  out  1  result_data valid
- res_data  out  DATA_W  captured result
- res_ready  in  1  consumer takes result
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE; word counter=0; opnd_bus=0; dp_op=0; dp_start=0; res_valid=0; res_data=0; load_ready=1 once rst deasserts.
- States: IDLE, LOAD, EXEC, WAIT, DONE.
- load_ready = 1 in IDLE and LOAD only. res_valid = 1 in DONE only, so the two are never high together.
- Accept = load_valid & load_ready & ~abort. The k-th accepted word (k from 0) goes to slot k.
- Required count: REQ = RELU_WORDS if op==3, else NUM_WORDS.
- IDLE: on accept, latch op_sel into dp_op, write slot 0, counter=1. If REQ==1 go to EXEC, else go to LOAD.
- LOAD: on accept, write slot[counter], counter++. The accept that makes counter==REQ goes to EXEC. Cycles with load_valid=0 are idle stalls with no state change.
- EXEC: exactly one cycle. dp_start=1, wait counter=DP_LAT-1, go to WAIT. opnd_bus and dp_op stay stable from EXEC until DONE is left.
- WAIT: decrement the wait counter each cycle. In the cycle it reads 0, register dp_result into res_data and go to DONE.
- Latency: last word accepted in cycle N; dp_start in cycle N+1; dp_result sampled in cycle N+DP_LAT+1; res_valid high from cycle N+DP_LAT+2.
- DONE: hold res_data and res_valid until res_ready=1. In that cycle: go to IDLE, clear opnd_bus, counter=0. res_valid drops the next cycle. A new word can be accepted in the cycle after the handshake (no same-cycle turnaround).
- Unused slots (indices >= REQ) stay 0.
- abort=1 in any state: next state IDLE; opnd_bus, counter and res_valid cleared. res_data keeps its value. abort overrides a simultaneous accept or res_ready. dp_start is not issued in the abort cycle.
- op_sel changes after the first accepted word are ignored until the next IDLE.

Optional Feature:
- Macro: CONV_SEQ_PERF_EN.
- When defined:
  - Adds output perf_cycles [15:0] and input perf_clr.
  - perf_cycles counts cycles from the first accepted word to entry into DONE, inclusive, and saturates at 16'hFFFF.
  - The count is frozen in DONE and restarts at 1 on the next first accept.
  - perf_clr=1 or rst sets it to 0.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cnn_seq_pkg holds:
  - the op encodings (OP_WINO, OP_PRUNED, OP_CONV2D, OP_RELU)
  - the state enum
  - NUM_WORDS/RELU_WORDS defaults and the slot-index width
- One natural sub-module: conv_opnd_bank. It is NUM_WORDS x DATA_W registers with write-enable, write index and synchronous clear, and drives opnd_bus. FSM and counters stay in the top.

Test Plan:
- op=2, words 1..14 with load_valid held, DP_LAT=2, dp_result=32'hA5A5_0001 -> slot k = k+1; dp_start exactly 1 cycle after the 14th accept; res_valid 4 cycles after the 14th accept; res_data=A5A5_0001.
- op=3, words 32'h0000_0F80 and 32'h0000_0F80 -> EXEC entered after 2 words; slots 2..13 = 0; dp_op=3.
- Stalls: load_valid toggled 1,0,0,1 across op=0 load -> counter advances only on valid cycles; 14 words still required.
- res_ready held 0 for 10 cycles in DONE -> res_valid and res_data stable, load_ready=0; on res_ready=1, next cycle IDLE, opnd_bus=0.
- abort asserted together with the 7th word -> 7th word not written; next cycle IDLE with opnd_bus=0; a following full load works normally.
- rst asserted mid-WAIT (asynchronously) -> all outputs zero immediately; no res_valid after release. With CONV_SEQ_PERF_EN: a gap-free op=0 load gives perf_cycles = 14+1+DP_LAT+1 = 18 for DP_LAT=2.
